siso_bist_seq: RTL

Built-in self-test sequencer for a serial-in/serial-out shift chain of known depth. On request it pushes a parallel test word into the chain's serial input MSB-first, flushes the chain, and reassembles the bits returning on the serial output. It then reports the received word, a pass/fail flag and a running failure count. It sits beside the SISO datapath and owns that datapath's d input while a test is in flight.

---
 rtl/siso_bist_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/siso_bist_seq.sv
// BIST sequencer for a serial-in/serial-out chain of DEPTH stages.
// It shifts a test word in MSB-first, flushes the chain, and checks the word that comes back.
module siso_bist_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic             busy,
  output logic             sr_d,
  input  logic             sr_v,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             match,
  output logic [7:0]       err_cnt
);

  localparam int TOTAL = WIDTH + DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] tx_q_reg, tx_q_next;
  logic [WIDTH-1:0] tx_sh_reg, tx_sh_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] rx_shifted;
  logic [WIDTH-1:0] tx_sh_adv;
  logic             sr_d_reg, sr_d_next;
  logic             match_reg, match_next;
  logic [7:0]       err_reg, err_next;
  logic             in_flight;

  // Receive word shifted left by one with the returning chain bit entering at the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rx
      if (gi == 0) begin : g_lsb
        assign rx_shifted[gi] = sr_v;
      end else begin : g_up
        assign rx_shifted[gi] = rx_reg[gi-1];
      end
    end
  endgenerate

  // tx_sh_reg always has the bit currently on sr_d in its MSB.
  assign tx_sh_adv = tx_sh_reg << 1;
  assign in_flight = (state_reg == SHIFT) || (state_reg == DRAIN);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tx_q_next  = tx_q_reg;
    tx_sh_next = tx_sh_reg;
    rx_next    = rx_reg;
    match_next = match_reg;
    err_next   = err_reg;
    sr_d_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          tx_q_next  = tx_data;
          tx_sh_next = tx_data;
          rx_next    = '0;
          match_next = 1'b0;
          sr_d_next  = tx_data[WIDTH-1];
        end
      end
      SHIFT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == SHIFT_LAST) begin
          state_next = DRAIN;
        end else begin
          tx_sh_next = tx_sh_adv;
          sr_d_next  = tx_sh_adv[WIDTH-1];
        end
      end
      DRAIN: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (!match_reg && (err_reg != 8'hFF)) begin
          err_next = err_reg + 8'd1;
        end
      end
    endcase

    // Bits from before the test occupy the first DEPTH cycles and are skipped.
    if (in_flight && (cnt_reg >= CAP_FIRST)) begin
      rx_next = rx_shifted;
    end

    // Compare on the final capture so match is already valid while done is high.
    if ((state_reg == DRAIN) && (cnt_reg == DRAIN_LAST)) begin
      match_next = (rx_shifted == tx_q_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tx_q_reg  <= '0;
      tx_sh_reg <= '0;
      rx_reg    <= '0;
      match_reg <= 1'b0;
      err_reg   <= 8'd0;
      sr_d_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tx_q_reg  <= tx_q_next;
      tx_sh_reg <= tx_sh_next;
      rx_reg    <= rx_next;
      match_reg <= match_next;
      err_reg   <= err_next;
      sr_d_reg  <= sr_d_next;
    end
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign sr_d    = sr_d_reg;
  assign rx_data = rx_reg;
  assign match   = match_reg;
  assign err_cnt = err_reg;

endmodule
